// File: rtl/sample_responder_if.sv
// rtl/sample_responder_if.sv - sample memory and network datapath bus of the sample responder
interface sample_responder_if #(
   parameter int BITS = 16
) ();
   logic            mem_rd;
   logic [BITS-1:0] mem_addr;
   logic [BITS-1:0] mem_x;
   logic [BITS-1:0] mem_t;
   logic            net_valid;
   logic            net_ready;
   logic            net_mode;
   logic [BITS-1:0] net_x;
   logic            net_done;
   logic [BITS-1:0] net_y;

   modport master (
      output mem_rd, mem_addr, net_valid, net_mode, net_x,
      input  mem_x, mem_t, net_ready, net_done, net_y
   );

   modport slave (
      input  mem_rd, mem_addr, net_valid, net_mode, net_x,
      output mem_x, mem_t, net_ready, net_done, net_y
   );
endinterface

// File: rtl/sample_responder.sv
// rtl/sample_responder.sv - fetch sample/target, run datapath step, report train/validation result
// Optional squared validation error selected by SQ_ERROR_EN.
module sample_responder #(
   parameter int BITS = 16,
   parameter int FRAC = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tr_req,
   input  logic            vl_req,
   input  logic [BITS-1:0] TRAIN,
   input  logic [BITS-1:0] VALID,
   sample_responder_if.master bus,
   output logic            s_train,
   output logic            s_error,
   output logic [BITS-1:0] error,
   output logic            busy,
   output logic            overrun
);
   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, ISSUE, WAIT_NET,
`ifdef SQ_ERROR_EN
      SQUARE,
`endif
      REPORT
   } state_t;

   localparam logic [BITS:0] SAT = {2'b00, {(BITS-1){1'b1}}};

   if (FRAC >= 2*BITS) begin : g_frac_range
      $error("FRAC must be below 2*BITS");
   end

   state_t            state, next;
   logic [BITS-1:0]   target, tr_idx, vl_idx;
   logic signed [BITS:0] diff;
   logic [BITS:0]     mag;
   logic [BITS-1:0]   mag_sat;
   logic              req_any;

   assign req_any = tr_req | vl_req;

   // Prediction and target are both signed; one extra bit keeps the difference exact.
   always_comb begin
      diff    = $signed({bus.net_y[BITS-1], bus.net_y}) - $signed({target[BITS-1], target});
      mag     = diff[BITS] ? $unsigned(-diff) : $unsigned(diff);
      mag_sat = (mag > SAT) ? SAT[BITS-1:0] : mag[BITS-1:0];
   end

`ifdef SQ_ERROR_EN
   localparam logic [2*BITS-1:0] SAT2 = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
   logic [BITS-1:0]   mag_q;
   logic [2*BITS-1:0] prod, scaled;

   always_comb begin
      prod   = {{BITS{1'b0}}, mag_q} * {{BITS{1'b0}}, mag_q};
      scaled = prod >> FRAC;
   end
`endif

   always_comb begin
      next = state;
      case (state)
         IDLE:     if (req_any) next = FETCH;
         FETCH:    next = LOAD;
         LOAD:     next = ISSUE;
         ISSUE:    if (bus.net_ready) next = WAIT_NET;
         WAIT_NET: begin
            if (bus.net_done) begin
`ifdef SQ_ERROR_EN
               next = bus.net_mode ? REPORT : SQUARE;
`else
               next = REPORT;
`endif
            end
         end
`ifdef SQ_ERROR_EN
         SQUARE:   next = REPORT;
`endif
         REPORT:   next = IDLE;
         default:  next = IDLE;
      endcase
   end

   // Strobes are decoded from next so every output leaves a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         busy          <= 1'b0;
         bus.mem_rd    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.net_valid <= 1'b0;
         bus.net_mode  <= 1'b0;
         bus.net_x     <= '0;
         target        <= '0;
         tr_idx        <= '0;
         vl_idx        <= '0;
         error         <= '0;
         s_train       <= 1'b0;
         s_error       <= 1'b0;
         overrun       <= 1'b0;
`ifdef SQ_ERROR_EN
         mag_q         <= '0;
`endif
      end else begin
         state         <= next;
         busy          <= (next != IDLE);
         bus.mem_rd    <= (next == FETCH);
         bus.net_valid <= (next == ISSUE);
         s_train       <= (next == REPORT) &&  bus.net_mode;
         s_error       <= (next == REPORT) && !bus.net_mode;

         if (state == IDLE && req_any) begin
            bus.net_mode <= tr_req;
            bus.mem_addr <= tr_req ? tr_idx : TRAIN + vl_idx;
         end

         if ((state != IDLE && req_any) || (state == IDLE && tr_req && vl_req))
            overrun <= 1'b1;

         if (state == LOAD) begin
            bus.net_x <= bus.mem_x;
            target    <= bus.mem_t;
         end

         if (state == WAIT_NET && bus.net_done && !bus.net_mode) begin
`ifdef SQ_ERROR_EN
            mag_q <= mag_sat;
`else
            error <= mag_sat;
`endif
         end

`ifdef SQ_ERROR_EN
         if (state == SQUARE)
            error <= (scaled > SAT2) ? SAT2[BITS-1:0] : scaled[BITS-1:0];
`endif

         if (state == REPORT) begin
            if (bus.net_mode)
               tr_idx <= (tr_idx == TRAIN - BITS'(1)) ? '0 : tr_idx + BITS'(1);
            else
               vl_idx <= (vl_idx == VALID - BITS'(1)) ? '0 : vl_idx + BITS'(1);
         end
      end
   end
endmodule

// File: tb/tb_sample_responder.sv
// tb/tb_sample_responder.sv - randomized timeline-model bench for sample_responder
module tb_sample_responder;
   localparam int BITS = 16;
   localparam int FRAC = 8;
   localparam int NC   = 4096;
`ifdef SQ_ERROR_EN
   localparam int SQX = 1;
`else
   localparam int SQX = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tr_req = 1'b0;
   logic        vl_req = 1'b0;
   logic [15:0] TRAIN = 16'd3;
   logic [15:0] VALID = 16'd2;
   logic        s_train, s_error, busy, overrun;
   logic [15:0] error;

   sample_responder_if #(.BITS(BITS)) bus ();

   sample_responder #(.BITS(BITS), .FRAC(FRAC)) dut (
      .clk(clk), .rst_n(rst_n), .tr_req(tr_req), .vl_req(vl_req),
      .TRAIN(TRAIN), .VALID(VALID), .bus(bus),
      .s_train(s_train), .s_error(s_error), .error(error),
      .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Timeline model: expected value of every output, indexed by cycle number.
   bit          e_rd[NC], e_val[NC], e_st[NC], e_se[NC], e_busy[NC], e_mode[NC];
   logic [15:0] e_addr[NC], e_x[NC], e_errv[NC];
   logic [15:0] mx[64], mt[64];
   int          tr_m, vl_m, ovr_from;
   logic [15:0] cur_err;
   int          pass_n = 0, tot_n = 0;
   bit          chk_en = 1'b0;
   int          addr_q[$];
   int          last_rep;

   task automatic check(input string nm, input int act, input int exp);
      tot_n++;
      if (act == exp) pass_n++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
   endtask

   function automatic int qat(input int i);
      return (i < addr_q.size()) ? addr_q[i] : -1;
   endfunction

   function automatic logic [15:0] ref_err(input logic [15:0] y, input logic [15:0] t);
      int     d, a;
      longint p;
      d = int'($signed(y)) - int'($signed(t));
      a = (d < 0) ? -d : d;
      if (a > 32767) a = 32767;
      p = (longint'(a) * longint'(a)) >> FRAC;
      if (p > 32767) p = 32767;
      return (SQX != 0) ? 16'(p) : 16'(a);
   endfunction

   // Sample memory: data appears the cycle after the read strobe.
   bit          rd_s = 1'b0;
   logic [15:0] a_s = '0;
   always @(negedge clk) begin
      rd_s = bus.mem_rd;
      a_s  = bus.mem_addr;
   end
   always @(posedge clk) begin
      #1;
      if (rd_s) begin
         bus.mem_x = mx[a_s[5:0]];
         bus.mem_t = mt[a_s[5:0]];
      end else begin
         bus.mem_x = 16'($urandom);
         bus.mem_t = 16'($urandom);
      end
   end

   always @(negedge clk) begin
      if (chk_en && cyc < NC) begin
         check("mem_rd", bus.mem_rd, e_rd[cyc]);
         if (e_rd[cyc]) check("mem_addr", bus.mem_addr, e_addr[cyc]);
         check("net_valid", bus.net_valid, e_val[cyc]);
         if (e_val[cyc]) begin
            check("net_x", bus.net_x, e_x[cyc]);
            check("net_mode", bus.net_mode, e_mode[cyc]);
         end
         check("s_train", s_train, e_st[cyc]);
         check("s_error", s_error, e_se[cyc]);
         check("busy", busy, e_busy[cyc]);
         check("overrun", overrun, int'(cyc >= ovr_from));
         if (e_se[cyc]) cur_err = e_errv[cyc];
         check("error", error, cur_err);
         if (bus.mem_rd) addr_q.push_back(int'(bus.mem_addr));
         if (s_train || s_error) last_rep = cyc;
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NC; i++) begin
         e_rd[i] = 0; e_val[i] = 0; e_st[i] = 0; e_se[i] = 0; e_busy[i] = 0; e_mode[i] = 0;
         e_addr[i] = '0; e_x[i] = '0; e_errv[i] = '0;
      end
      tr_m = 0; vl_m = 0; cur_err = '0; ovr_from = 1 << 30;
      addr_q.delete();
   endtask

   task automatic do_reset(input logic [15:0] tn, input logic [15:0] vn);
      chk_en = 1'b0;
      rst_n = 1'b0;
      tr_req = 1'b0; vl_req = 1'b0;
      bus.net_ready = 1'b0; bus.net_done = 1'b0;
      TRAIN = tn; VALID = vn;
      next(); next();
      clear_model();
      rst_n = 1'b1;
      chk_en = 1'b1;
   endtask

   // kind: 0 train, 1 validation, 2 both at once; r = ready stall, dl = extra wait for done.
   task automatic run_step(input int kind, input int r, input int dl, input bit stray,
                           input logic [15:0] y, output int k_out);
      int k, addr, rr;
      bit md;
      k = cyc;
      md = (kind != 1);
      addr = md ? tr_m : ((int'(TRAIN) + vl_m) & 16'hFFFF);
      rr = k + 5 + r + dl + ((!md) ? SQX : 0);
      if (rr + 2 >= NC) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", rr, NC);
         $fatal(1);
      end
      if (kind == 2 && ovr_from > k + 1) ovr_from = k + 1;
      if (stray && ovr_from > k + 3) ovr_from = k + 3;
      e_rd[k+1] = 1; e_addr[k+1] = 16'(addr);
      for (int c = k + 1; c <= rr; c++) e_busy[c] = 1;
      for (int c = k + 3; c <= k + 3 + r; c++) begin
         e_val[c] = 1; e_x[c] = mx[addr & 63]; e_mode[c] = md;
      end
      if (md) e_st[rr] = 1;
      else begin
         e_se[rr] = 1;
         e_errv[rr] = ref_err(y, mt[addr & 63]);
      end
      last_rep = -1;
      for (int c = k; c <= rr; c++) begin
         tr_req = (c == k) && (kind != 1);
         vl_req = ((c == k) && (kind != 0)) || (stray && c == k + 2);
         bus.net_ready = (c == k + 3 + r);
         bus.net_done  = (c == k + 4 + r + dl);
         bus.net_y     = (c == k + 4 + r + dl) ? y : 16'($urandom);
         next();
      end
      tr_req = 1'b0; vl_req = 1'b0; bus.net_ready = 1'b0; bus.net_done = 1'b0;
      if (md) tr_m = (tr_m + 1 == int'(TRAIN)) ? 0 : tr_m + 1;
      else    vl_m = (vl_m + 1 == int'(VALID)) ? 0 : vl_m + 1;
      k_out = k;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.net_done  = 1'($urandom_range(0, 1));
         bus.net_ready = 1'($urandom_range(0, 1));
         bus.net_y     = 16'($urandom);
         next();
      end
      bus.net_done = 1'b0; bus.net_ready = 1'b0;
   endtask

   initial begin
      int k;
      bus.net_ready = 1'b0; bus.net_done = 1'b0; bus.net_y = '0;
      for (int i = 0; i < 64; i++) begin
         mx[i] = 16'($urandom);
         mt[i] = 16'($urandom);
      end
      next();
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_overrun", overrun, 0);
      check("rst_net_x", bus.net_x, 0);
      check("rst_strobes", {bus.mem_rd, bus.net_valid, s_train, s_error}, 0);

      // Train sequence with zero-wait datapath
      do_reset(16'd3, 16'd2);
      for (int i = 0; i < 4; i++) begin
         run_step(0, 0, 0, 0, 16'($urandom), k);
         check("train_latency", last_rep - k, 5);
      end
      check("train_addr0", qat(0), 0);
      check("train_addr1", qat(1), 1);
      check("train_addr2", qat(2), 2);
      check("train_addr3", qat(3), 0);

      // Validation error and saturation
      do_reset(16'd4, 16'd2);
      mt[4] = 16'h0100;
      run_step(1, 0, 0, 0, 16'h00C0, k);
      check("val_err_small", error, (SQX != 0) ? 16'h0010 : 16'h0040);
      check("val_latency", last_rep - k, 5 + SQX);
      mt[5] = 16'h7FFF;
      run_step(1, 0, 0, 0, 16'h8000, k);
      check("val_err_sat", error, 16'h7FFF);
      mt[4] = 16'h0100;
      run_step(1, 0, 0, 0, 16'h0300, k);
      check("val_err_0200", error, (SQX != 0) ? 16'h0400 : 16'h0200);
      check("val_addr0", qat(0), 4);
      check("val_addr1", qat(1), 5);
      check("val_addr2", qat(2), 4);

      // Handshake stall
      run_step(0, 7, 0, 0, 16'($urandom), k);
      check("stall_latency", last_rep - k, 12);
      check("stall_reads", addr_q.size(), 4);

      // Randomized mix
      do_reset(16'd5, 16'd3);
      for (int i = 0; i < 40; i++) begin
         run_step($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3), 0,
                  16'($urandom), k);
         idle($urandom_range(0, 2));
      end

      // Collision and request during LOAD
      check("ovr_clear", overrun, 0);
      run_step(2, 0, 0, 0, 16'($urandom), k);
      check("ovr_collision", overrun, 1);
      run_step(1, 1, 2, 1, 16'($urandom), k);
      check("ovr_sticky", overrun, 1);

      // Validation address wraps modulo 2^BITS
      do_reset(16'hFFFE, 16'd3);
      for (int i = 0; i < 4; i++) run_step(1, $urandom_range(0, 2), 0, 0, 16'($urandom), k);
      check("wrap_addr0", qat(0), 16'hFFFE);
      check("wrap_addr1", qat(1), 16'hFFFF);
      check("wrap_addr2", qat(2), 16'h0000);
      check("wrap_addr3", qat(3), 16'hFFFE);

      // Reset in WAIT_NET
      do_reset(16'd6, 16'd2);
      mt[6] = 16'h0010;
      run_step(1, 0, 0, 0, 16'h0250, k);
      run_step(0, 0, 0, 0, 16'($urandom), k);
      check("pre_rst_error_nonzero", int'(error != 16'h0000), 1);
      chk_en = 1'b0;
      tr_req = 1'b1; next(); tr_req = 1'b0;
      next(); next();
      bus.net_ready = 1'b1; next(); bus.net_ready = 1'b0;
      next();
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_error", error, 0);
      check("midrst_net_valid", bus.net_valid, 0);
      check("midrst_net_x", bus.net_x, 0);
      next();
      clear_model();
      rst_n = 1'b1;
      chk_en = 1'b1;
      run_step(0, 0, 0, 0, 16'($urandom), k);
      check("midrst_addr", qat(0), 0);
      idle(3);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
